vi_stream_tx: RTL



---
 rtl/vi_pkg.sv | 46 ++++
 rtl/vi_timing_cnt.sv | 61 ++++++
 rtl/vi_stream_tx.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/vi_pkg.sv
// Shared definitions for the video transmit path: FSM state encoding,
// RGB565 colour constants and raster timing-total helpers.
package vi_pkg;

  localparam int unsigned DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALIGN = 2'd1,
    ST_RUN   = 2'd2
  } vi_state_t;

  localparam logic [DATA_W-1:0] RGB_WHITE   = 16'hFFFF;
  localparam logic [DATA_W-1:0] RGB_YELLOW  = 16'hFFE0;
  localparam logic [DATA_W-1:0] RGB_CYAN    = 16'h07FF;
  localparam logic [DATA_W-1:0] RGB_GREEN   = 16'h07E0;
  localparam logic [DATA_W-1:0] RGB_MAGENTA = 16'hF81F;
  localparam logic [DATA_W-1:0] RGB_RED     = 16'hF800;
  localparam logic [DATA_W-1:0] RGB_BLUE    = 16'h001F;
  localparam logic [DATA_W-1:0] RGB_BLACK   = 16'h0000;

  // Total clocks per line (or lines per frame) from display + porch/sync widths.
  function automatic int unsigned vi_total(input int unsigned disp,
                                           input int unsigned fp,
                                           input int unsigned sync,
                                           input int unsigned bp);
    return disp + fp + sync + bp;
  endfunction

  // Colour of vertical bar idx (0 = leftmost) in the standard 8-bar pattern.
  function automatic logic [DATA_W-1:0] vi_bar_colour(input logic [2:0] idx);
    logic [DATA_W-1:0] c;
    case (idx)
      3'd0:    c = RGB_WHITE;
      3'd1:    c = RGB_YELLOW;
      3'd2:    c = RGB_CYAN;
      3'd3:    c = RGB_GREEN;
      3'd4:    c = RGB_MAGENTA;
      3'd5:    c = RGB_RED;
      3'd6:    c = RGB_BLUE;
      default: c = RGB_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vi_timing_cnt.sv
// Raster timing generator: free-running h/v counters plus active-region and
// sync decode. Counters are held at (0,0) while clr is asserted.
module vi_timing_cnt
  import vi_pkg::*;
#(
  parameter int unsigned          CNT_WIDTH = 12,
  parameter logic [CNT_WIDTH-1:0] H_DISP    = 12'd1280,
  parameter logic [CNT_WIDTH-1:0] H_FP      = 12'd110,
  parameter logic [CNT_WIDTH-1:0] H_SYNC    = 12'd40,
  parameter logic [CNT_WIDTH-1:0] H_BP      = 12'd220,
  parameter logic [CNT_WIDTH-1:0] V_DISP    = 12'd720,
  parameter logic [CNT_WIDTH-1:0] V_FP      = 12'd5,
  parameter logic [CNT_WIDTH-1:0] V_SYNC    = 12'd5,
  parameter logic [CNT_WIDTH-1:0] V_BP      = 12'd20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] h_cnt,
  output logic [CNT_WIDTH-1:0] v_cnt,
  output logic                 active,
  output logic                 hs,
  output logic                 vs,
  output logic                 frame_end
);

  localparam logic [CNT_WIDTH-1:0] H_TOTAL =
    CNT_WIDTH'(vi_total(32'(H_DISP), 32'(H_FP), 32'(H_SYNC), 32'(H_BP)));
  localparam logic [CNT_WIDTH-1:0] V_TOTAL =
    CNT_WIDTH'(vi_total(32'(V_DISP), 32'(V_FP), 32'(V_SYNC), 32'(V_BP)));
  localparam logic [CNT_WIDTH-1:0] H_LAST   = H_TOTAL - CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] V_LAST   = V_TOTAL - CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] HS_START = H_DISP + H_FP;
  localparam logic [CNT_WIDTH-1:0] HS_END   = H_DISP + H_FP + H_SYNC;
  localparam logic [CNT_WIDTH-1:0] VS_START = V_DISP + V_FP;
  localparam logic [CNT_WIDTH-1:0] VS_END   = V_DISP + V_FP + V_SYNC;

  logic line_end;

  assign line_end  = (h_cnt == H_LAST);
  assign frame_end = line_end && (v_cnt == V_LAST);

  // Position decode; vs follows the same rule on lines so it spans whole lines.
  assign active = (h_cnt < H_DISP) && (v_cnt < V_DISP);
  assign hs     = (h_cnt >= HS_START) && (h_cnt < HS_END);
  assign vs     = (v_cnt >= VS_START) && (v_cnt < VS_END);

  // h wraps at end of line and steps v; v wraps at end of frame.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (line_end) begin
      h_cnt <= '0;
      v_cnt <= frame_end ? '0 : v_cnt + CNT_WIDTH'(1);
    end else begin
      h_cnt <= h_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/vi_stream_tx.sv
// Video stream transmitter: pulls RGB565 pixels from an upstream source over
// valid/ready, aligns to the source's start-of-frame marker and emits a
// raster-timed vs/hs/de/data stream one clock after the counter position.
// Optional build macro VI_TX_TEST_PATTERN_EN adds an 8-colour-bar generator
// selected by tp_en; without it tp_en is ignored.
module vi_stream_tx
  import vi_pkg::*;
#(
  parameter int unsigned          CNT_WIDTH = 12,
  parameter logic [CNT_WIDTH-1:0] H_DISP    = 12'd1280,
  parameter logic [CNT_WIDTH-1:0] H_FP      = 12'd110,
  parameter logic [CNT_WIDTH-1:0] H_SYNC    = 12'd40,
  parameter logic [CNT_WIDTH-1:0] H_BP      = 12'd220,
  parameter logic [CNT_WIDTH-1:0] V_DISP    = 12'd720,
  parameter logic [CNT_WIDTH-1:0] V_FP      = 12'd5,
  parameter logic [CNT_WIDTH-1:0] V_SYNC    = 12'd5,
  parameter logic [CNT_WIDTH-1:0] V_BP      = 12'd20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              tp_en,
  input  logic              pix_valid,
  input  logic              pix_sof,
  input  logic [DATA_W-1:0] pix_data,
  output logic              pix_ready,
  output logic              vo_vs,
  output logic              vo_hs,
  output logic              vo_de,
  output logic [DATA_W-1:0] vo_data,
  output logic              frame_done,
  output logic              underflow
);

  localparam logic [CNT_WIDTH-1:0] H_LAST_PIX = H_DISP - CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] V_LAST_PIX = V_DISP - CNT_WIDTH'(1);

  vi_state_t            state;
  vi_state_t            state_nxt;
  logic [CNT_WIDTH-1:0] h_cnt;
  logic [CNT_WIDTH-1:0] v_cnt;
  logic                 t_active;
  logic                 t_hs;
  logic                 t_vs;
  logic                 frame_end;
  logic                 cnt_clr;
  logic                 tp_mode;
  logic [DATA_W-1:0]    tp_data;
  logic                 at_origin;
  logic                 last_pix;
  logic                 in_run;
  logic                 sof_mis;
  logic                 underrun;
  logic                 run_out;
  logic [DATA_W-1:0]    pix_sel;
  logic                 en_q;
  logic                 en_rise;

  logic                 vs_p1;
  logic                 hs_p1;
  logic                 vld_p1;
  logic [DATA_W-1:0]    data_p1;
  logic                 done_p1;
  logic                 uf_p1;

`ifdef VI_TX_TEST_PATTERN_EN
  localparam logic [CNT_WIDTH-1:0] BAR_W = H_DISP / CNT_WIDTH'(8);
  logic [2:0] bar_idx;
  assign tp_mode = tp_en;
  assign bar_idx = 3'(h_cnt / BAR_W);
  assign tp_data = vi_bar_colour(bar_idx);
`else
  logic unused_tp;
  assign tp_mode   = 1'b0;
  assign tp_data   = '0;
  assign unused_tp = tp_en;
`endif

  // Counters run only while staying in RUN; any exit (or non-RUN state)
  // parks them at (0,0) so the next RUN entry starts a fresh frame.
  assign cnt_clr = (state != ST_RUN) || (state_nxt != ST_RUN);

  vi_timing_cnt #(
    .CNT_WIDTH (CNT_WIDTH),
    .H_DISP    (H_DISP),
    .H_FP      (H_FP),
    .H_SYNC    (H_SYNC),
    .H_BP      (H_BP),
    .V_DISP    (V_DISP),
    .V_FP      (V_FP),
    .V_SYNC    (V_SYNC),
    .V_BP      (V_BP)
  ) u_timing (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (cnt_clr),
    .h_cnt     (h_cnt),
    .v_cnt     (v_cnt),
    .active    (t_active),
    .hs        (t_hs),
    .vs        (t_vs),
    .frame_end (frame_end)
  );

  assign at_origin = (h_cnt == '0) && (v_cnt == '0);
  assign last_pix  = (h_cnt == H_LAST_PIX) && (v_cnt == V_LAST_PIX);
  assign in_run    = (state == ST_RUN) && !tp_mode;

  // A sof anywhere but (0,0) means the source restarted a frame: realign.
  // Without pix_valid it is just a missing pixel, so no realign then.
  assign sof_mis  = in_run && t_active && pix_valid && pix_sof && !at_origin;
  assign underrun = in_run && t_active && !pix_valid;
  assign en_rise  = en && !en_q;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; en is honoured in RUN only at the frame wrap.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (en) state_nxt = tp_mode ? ST_RUN : ST_ALIGN;
      end
      ST_ALIGN: begin
        if (tp_mode || (pix_valid && pix_sof)) state_nxt = ST_RUN;
        else if (!en)                          state_nxt = ST_IDLE;
      end
      ST_RUN: begin
        if (sof_mis)                state_nxt = ST_ALIGN;
        else if (frame_end && !en)  state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output decode: ready, whether this cycle drives the raster, pixel select.
  always_comb begin
    pix_ready = 1'b0;
    run_out   = 1'b0;
    pix_sel   = '0;
    case (state)
      ST_ALIGN: begin
        pix_ready = !pix_sof && !tp_mode;
      end
      ST_RUN: begin
        if (tp_mode) begin
          run_out = 1'b1;
          pix_sel = t_active ? tp_data : '0;
        end else begin
          pix_ready = t_active && !(pix_sof && !at_origin);
          run_out   = !sof_mis;
          pix_sel   = (t_active && pix_valid) ? pix_data : '0;
        end
      end
      default: ;
    endcase
  end

  // ---- stage p1: registered raster outputs, one clock after the counters ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vs_p1   <= 1'b0;
      hs_p1   <= 1'b0;
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      done_p1 <= 1'b0;
    end else begin
      vs_p1   <= run_out && t_vs;
      hs_p1   <= run_out && t_hs;
      vld_p1  <= run_out && t_active;
      data_p1 <= run_out ? pix_sel : '0;
      done_p1 <= run_out && last_pix;
    end
  end

  // Sticky underflow; a new enable (en 0->1) clears it, a fresh underrun wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_q  <= 1'b0;
      uf_p1 <= 1'b0;
    end else begin
      en_q  <= en;
      uf_p1 <= (uf_p1 && !en_rise) || underrun;
    end
  end

  assign vo_vs      = vs_p1;
  assign vo_hs      = hs_p1;
  assign vo_de      = vld_p1;
  assign vo_data    = data_p1;
  assign frame_done = done_p1;
  assign underflow  = uf_p1;

endmodule
